// File: rtl/wb_pkg.sv
// Shared Wishbone helpers for timeout and watchdog logic.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package wb_pkg;

  localparam int WB_TIMEOUT_DEFAULT = 1024;

  // Bridge states; also decoded by bus-monitor logic.
  typedef enum logic [2:0] {
    TO_IDLE,
    TO_REQ,
    TO_WAIT,
    TO_RESP,
    TO_ABORT
  } wb_to_state_t;

  // Timer width able to hold 0..cycles. A zero-cycle (disabled) timer still
  // needs one bit so that the port widths stay legal.
  function automatic int to_timer_width(input int cycles);
    return (cycles <= 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Watchdog timer: counts enabled cycles and flags the final one before LIMIT.
// Latency: expire is combinational from the count register and en.
// Backpressure: none; clr has priority over en. LIMIT=0 holds the count at 0.
// Ports: clk, rst_n, clr (restart at 0), en (count this cycle),
//        expire (this enabled cycle is cycle LIMIT of the window).
module wb_timeout_counter #(
  parameter int LIMIT = 1024,
  parameter int WIDTH = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  assign expire = (LIMIT != 0) && en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (LIMIT == 0)) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_slave_timeout_bridge.sv
// Registered Wishbone B4 pipelined stage with a hung-peripheral watchdog.
// Latency: request on m_* 1 cycle after upstream accept; response on s_* 1 cycle after m_ack/m_err.
// Backpressure: s_stall high outside IDLE, so exactly one transaction is in flight.
// Ports: s_* upstream slave side, m_* downstream master side,
//        timeout_pulse/timeout_cnt/last_to_adr log forced-error events.
module wb_slave_timeout_bridge
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 28,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_cyc,
  input  logic                    s_stb,
  input  logic                    s_we,
  input  logic [ADDR_WIDTH-1:0]   s_adr,
  input  logic [DATA_WIDTH-1:0]   s_dat_w,
  input  logic [DATA_WIDTH/8-1:0] s_sel,
  output logic                    s_stall,
  output logic                    s_ack,
  output logic                    s_err,
  output logic [DATA_WIDTH-1:0]   s_dat_r,
  output logic                    m_cyc,
  output logic                    m_stb,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_adr,
  output logic [DATA_WIDTH-1:0]   m_dat_w,
  output logic [DATA_WIDTH/8-1:0] m_sel,
  input  logic                    m_stall,
  input  logic                    m_ack,
  input  logic                    m_err,
  input  logic [DATA_WIDTH-1:0]   m_dat_r,
  output logic                    timeout_pulse,
  output logic [CNT_WIDTH-1:0]    timeout_cnt,
  output logic [ADDR_WIDTH-1:0]   last_to_adr
);

  localparam int TW = to_timer_width(TIMEOUT_CYCLES);

  wb_to_state_t state;
  logic         to_clr;
  logic         to_en;
  logic         to_expire;

  // The window restarts when the strobe is accepted, so a slow accept
  // and a slow response each get the full TIMEOUT_CYCLES.
  assign to_clr = (state == TO_IDLE) || ((state == TO_REQ) && !m_stall);
  assign to_en  = (state == TO_REQ) || (state == TO_WAIT);

  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (to_clr),
    .en     (to_en),
    .expire (to_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= TO_IDLE;
      s_stall       <= 1'b0;
      s_ack         <= 1'b0;
      s_err         <= 1'b0;
      s_dat_r       <= '0;
      m_cyc         <= 1'b0;
      m_stb         <= 1'b0;
      m_we          <= 1'b0;
      m_adr         <= '0;
      m_dat_w       <= '0;
      m_sel         <= '0;
      timeout_pulse <= 1'b0;
      timeout_cnt   <= '0;
      last_to_adr   <= '0;
    end else begin
      // Response strobes are single-cycle by construction.
      s_ack         <= 1'b0;
      s_err         <= 1'b0;
      s_dat_r       <= '0;
      timeout_pulse <= 1'b0;

      case (state)
        TO_IDLE: begin
          if (s_cyc && s_stb) begin
            m_adr   <= s_adr;
            m_dat_w <= s_dat_w;
            m_we    <= s_we;
            m_sel   <= s_sel;
            m_cyc   <= 1'b1;
            m_stb   <= 1'b1;
            s_stall <= 1'b1;
            state   <= TO_REQ;
          end
        end

        TO_REQ: begin
          // An upstream abandon beats everything; an accept on the expiry
          // cycle beats the timeout because the peripheral did respond.
          if (!s_cyc) begin
            m_cyc <= 1'b0;
            m_stb <= 1'b0;
            state <= TO_ABORT;
          end else if (!m_stall) begin
            m_stb <= 1'b0;
            state <= TO_WAIT;
          end else if (to_expire) begin
            m_cyc         <= 1'b0;
            m_stb         <= 1'b0;
            s_err         <= 1'b1;
            timeout_pulse <= 1'b1;
            last_to_adr   <= m_adr;
            if (timeout_cnt != {CNT_WIDTH{1'b1}}) timeout_cnt <= timeout_cnt + CNT_WIDTH'(1);
            state         <= TO_RESP;
          end
        end

        TO_WAIT: begin
          // Priority: abandon, err, ack, then timeout.
          if (!s_cyc) begin
            m_cyc <= 1'b0;
            state <= TO_ABORT;
          end else if (m_err) begin
            m_cyc <= 1'b0;
            s_err <= 1'b1;
            state <= TO_RESP;
          end else if (m_ack) begin
            m_cyc   <= 1'b0;
            s_ack   <= 1'b1;
            s_dat_r <= m_dat_r;
            state   <= TO_RESP;
          end else if (to_expire) begin
            m_cyc         <= 1'b0;
            s_err         <= 1'b1;
            timeout_pulse <= 1'b1;
            last_to_adr   <= m_adr;
            if (timeout_cnt != {CNT_WIDTH{1'b1}}) timeout_cnt <= timeout_cnt + CNT_WIDTH'(1);
            state         <= TO_RESP;
          end
        end

        TO_RESP, TO_ABORT: begin
          s_stall <= 1'b0;
          state   <= TO_IDLE;
        end

        default: begin
          m_cyc   <= 1'b0;
          m_stb   <= 1'b0;
          s_stall <= 1'b0;
          state   <= TO_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_slave_timeout_bridge.md
Name: wb_slave_timeout_bridge

Overview:
- Pipelined Wishbone B4 stage inserted between one slave port of data_bus (upstream side) and a peripheral (downstream side), e.g. on DDR_CTRL_S or FLASH_USR_S.
- Registers the request and the response, allowing one outstanding transaction at a time.
- Guards against hung peripherals: if no ack/err arrives within TIMEOUT_CYCLES, it returns err upstream, aborts the cycle downstream and logs the event.

Parameters:
- ADDR_WIDTH, 28, word address width (matches interconnect AW).
- DATA_WIDTH, 32, data bus width; SEL width = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, cycles from downstream accept to forced error; 0 disables timeout.
- CNT_WIDTH, 16, width of saturating timeout event counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_cyc, s_stb, s_we  in  1 each  upstream request from data_bus slave port
- s_adr  in  ADDR_WIDTH  upstream word address
- s_dat_w  in  DATA_WIDTH  upstream write data
- s_sel  in  DATA_WIDTH/8  upstream byte selects
- s_stall  out  1  upstream stall
- s_ack, s_err  out  1 each  upstream response
- s_dat_r  out  DATA_WIDTH  upstream read data
- m_cyc, m_stb, m_we  out  1 each  downstream request
- m_adr  out  ADDR_WIDTH  downstream address
- m_dat_w  out  DATA_WIDTH  downstream write data
- m_sel  out  DATA_WIDTH/8  downstream byte selects
- m_stall, m_ack, m_err  in  1 each  downstream handshake
- m_dat_r  in  DATA_WIDTH  downstream read data
- timeout_pulse  out  1  one-cycle strobe per timeout event
- timeout_cnt  out  CNT_WIDTH  saturating count of timeouts
- last_to_adr  out  ADDR_WIDTH  address of most recent timed-out request

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except s_stall=0; state IDLE; timer 0.
- FSM states: IDLE, REQ, WAIT, RESP, ABORT.
- IDLE:
  - s_stall=0.
  - s_cyc&s_stb: latch adr/dat_w/we/sel into the request register, then go to REQ.
- REQ:
  - m_cyc=m_stb=1 with the latched request.
  - When !m_stall, the strobe is accepted; go to WAIT and clear the timer.
- WAIT:
  - m_cyc=1, m_stb=0; timer increments each cycle.
  - m_ack: capture m_dat_r and go to RESP(ack).
  - m_err: go to RESP(err).
  - Timer reaches TIMEOUT_CYCLES-1 with no ack/err: go to RESP(err) and set the timeout flag.
- RESP:
  - m_cyc=0.
  - Exactly one cycle of s_ack or s_err; s_dat_r valid with s_ack, 0 otherwise.
  - Then go to IDLE.
- Timeout side effects, applied in the RESP cycle:
  - timeout_pulse=1.
  - timeout_cnt incremented, saturating at all-ones.
  - last_to_adr loaded.
- Timer also runs in REQ: a peripheral that stalls forever times out the same way.
- Latency: the request appears on m_* 1 cycle after upstream accept; the response appears on s_* 1 cycle after m_ack/m_err.
- s_stall=1 in every state except IDLE, so there is strictly one outstanding transaction.
- Simultaneous events:
  - m_ack on the same cycle the timer expires: ack wins, no timeout logged.
  - m_ack and m_err together: err wins.
- Upstream s_cyc dropped while in REQ/WAIT: go to ABORT.
  - m_cyc=0 for one cycle, no upstream response, no timeout logged; then IDLE.
- Late m_ack/m_err arriving in IDLE or ABORT (after a timeout or abort): ignored.
- Timer width: $clog2(TIMEOUT_CYCLES+1). TIMEOUT_CYCLES=0 means the timer is held at 0 and never expires.
- Reset asserted mid-transaction: immediate return to reset values; downstream m_cyc drops asynchronously.

Decomposition:
- wb_pkg additions:
  - constant WB_TIMEOUT_DEFAULT=1024.
  - typedef wb_to_state_t enum for the five states, shared with future bus-monitor logic.
- One natural sub-module: wb_timeout_counter. It holds the timer with clear/enable/expire outputs and is reused by other watchdogs.

Test Plan:
- Single read: peripheral acks 3 cycles after accept with m_dat_r=32'hDEADBEEF. Required: s_ack one cycle, s_dat_r=DEADBEEF, no timeout_pulse, total upstream latency 5 cycles.
- Back-to-back writes to adr 0x100/0x101: second strobe sees s_stall=1 until the first s_ack. Required: m_* carries correct adr/dat/sel in order.
- Hung peripheral with TIMEOUT_CYCLES=16, never acks. Required: s_err exactly 16 cycles after accept (+1 register), m_cyc low, timeout_cnt=1, last_to_adr=request address, late m_ack ignored.
- m_ack arrives on the expiry cycle. Required: s_ack (not err), timeout_cnt unchanged.
- s_cyc dropped in WAIT. Required: m_cyc deasserts the following cycle, no s_ack/s_err, FSM back to IDLE within 2 cycles.
- timeout_cnt saturation and async reset: force 2^CNT_WIDTH+1 timeouts with CNT_WIDTH=4, requiring the count to stay at 0xF. Then pulse rst_n low mid-WAIT, requiring all outputs to be 0 immediately.
